note_lane_scroller: RTL and testbench

- Parametrised note-position engine for the Guitar Hero screen.
- Holds a table of SLOTS note slots, each with valid bit, lane index and vertical position.
- Accepts chord words from the chart reader, advances every active note by a programmable speed on each frame tick, and retires notes on a strum hit or when they fall past the hit window.
- Sits between the chart ROM reader (Notes.mem) and VGAController, which reads slots back for drawing.

---
 rtl/note_pkg.sv | 24 ++
 rtl/note_slot_pick.sv | 23 ++
 rtl/note_lane_scroller.sv | 256 +++++++++++++++++++++++++
 tb/tb_note_lane_scroller.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/note_pkg.sv
// Shared note-engine types and default screen geometry for the scroller and the VGA drawing side.
// Both sides take the hit line and spawn row from here so the drawn window matches the scored one.
package note_pkg;

  localparam int DEF_SPAWN_Y = 0;
  localparam int DEF_HIT_Y   = 420;
  localparam int DEF_HIT_WIN = 16;
  localparam int DEF_LANES   = 4;
  localparam int DEF_LANE_W  = 2;
  localparam int DEF_POS_W   = 10;

  typedef enum logic {
    IDLE  = 1'b0,
    ALLOC = 1'b1
  } alloc_state_e;

  // Slot record at the default screen geometry, as read back by the drawing side.
  typedef struct packed {
    logic                  valid;
    logic [DEF_LANE_W-1:0] lane;
    logic [DEF_POS_W-1:0]  pos;
  } note_slot_t;

endpackage

// File: rtl/note_slot_pick.sv
// Lowest-index priority encoder over an N-bit mask; combinational, no backpressure.
// Used for free-slot search, strum tie-breaking and picking the next pending chord lane.
module note_slot_pick #(
  parameter  int N  = 40,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  mask_i,
  output logic [IW-1:0] idx_o,
  output logic          found_o
);

  always_comb begin
    idx_o   = '0;
    found_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask_i[i]) begin
        idx_o   = IW'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/note_lane_scroller.sv
// Note-position engine: allocates chord notes into a slot table, scrolls them per frame tick, scores strums.
// hit/miss/bad_strum, read data and active_count are registered (1 cycle); chart_ready drops while a chord is allocated.
module note_lane_scroller
  import note_pkg::*;
#(
  parameter  int LANES   = DEF_LANES,
  parameter  int SLOTS   = 40,
  parameter  int POS_W   = DEF_POS_W,
  parameter  int SPEED_W = 4,
  parameter  int SPAWN_Y = DEF_SPAWN_Y,
  parameter  int HIT_Y   = DEF_HIT_Y,
  parameter  int HIT_WIN = DEF_HIT_WIN,
  localparam int IDX_W   = $clog2(SLOTS),
  localparam int LANE_W  = $clog2(LANES),
  localparam int CNT_W   = $clog2(SLOTS + 1)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               tick,
  input  logic [SPEED_W-1:0] speed,
  input  logic               chart_valid,
  input  logic [LANES-1:0]   chart_lanes,
  output logic               chart_ready,
  input  logic [LANES-1:0]   strum,
  output logic [LANES-1:0]   hit,
  output logic [LANES-1:0]   miss,
  output logic [LANES-1:0]   bad_strum,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic               rd_valid,
  output logic [LANE_W-1:0]  rd_lane,
  output logic [POS_W-1:0]   rd_pos,
  output logic [CNT_W-1:0]   active_count,
  output logic               overflow
);

  // Window bounds are one bit wider than a position so a window reaching past the screen edge still compares.
  localparam logic [POS_W:0]   WIN_LO    = (POS_W+1)'(HIT_Y - HIT_WIN);
  localparam logic [POS_W:0]   WIN_HI    = (POS_W+1)'(HIT_Y + HIT_WIN);
  localparam logic [POS_W-1:0] SPAWN_POS = POS_W'(SPAWN_Y);

  // Same layout as note_slot_t, but sized from this instance's parameters.
  typedef struct packed {
    logic              valid;
    logic [LANE_W-1:0] lane;
    logic [POS_W-1:0]  pos;
  } slot_rec_t;

  slot_rec_t    slots_q [SLOTS];
  slot_rec_t    slots_d [SLOTS];
  slot_rec_t    rd_slot;
  slot_rec_t    rd_q;
  alloc_state_e state_q, state_d;
  logic [LANES-1:0] pend_q, pend_d;
  logic [LANES-1:0] hit_q, hit_d;
  logic [LANES-1:0] miss_q, miss_d;
  logic [LANES-1:0] bad_q, bad_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  logic [SLOTS-1:0]  free_mask;
  logic [IDX_W-1:0]  free_idx;
  logic              free_found;
  logic [LANE_W-1:0] pend_lane;
  logic              pend_found;
  logic              alloc_we;
  logic [SLOTS-1:0]  cand      [LANES];
  logic [SLOTS-1:0]  best_mask [LANES];
  logic [POS_W-1:0]  best_pos  [LANES];
  logic [IDX_W-1:0]  pick_idx  [LANES];
  logic              pick_found[LANES];
  logic [SLOTS-1:0]  strum_free;
  logic [POS_W:0]    pos_sum   [SLOTS];
  logic [POS_W-1:0]  moved_pos [SLOTS];

  always_comb begin
    for (int s = 0; s < SLOTS; s++) begin
      free_mask[s] = ~slots_q[s].valid;
    end
  end

  note_slot_pick #(.N(SLOTS)) u_free_pick (
    .mask_i  (free_mask),
    .idx_o   (free_idx),
    .found_o (free_found)
  );

  note_slot_pick #(.N(LANES)) u_pend_pick (
    .mask_i  (pend_q),
    .idx_o   (pend_lane),
    .found_o (pend_found)
  );

  // Strum candidates use pre-tick positions; the deepest note wins, equal depths fall to the lowest index.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      cand[l]      = '0;
      best_mask[l] = '0;
      best_pos[l]  = '0;
    end
    for (int l = 0; l < LANES; l++) begin
      for (int s = 0; s < SLOTS; s++) begin
        cand[l][s] = slots_q[s].valid && (slots_q[s].lane == LANE_W'(l)) &&
                     ({1'b0, slots_q[s].pos} >= WIN_LO) && ({1'b0, slots_q[s].pos} <= WIN_HI);
        if (cand[l][s] && (slots_q[s].pos > best_pos[l])) begin
          best_pos[l] = slots_q[s].pos;
        end
      end
      for (int s = 0; s < SLOTS; s++) begin
        best_mask[l][s] = cand[l][s] && (slots_q[s].pos == best_pos[l]);
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_strum_pick
    note_slot_pick #(.N(SLOTS)) u_strum_pick (
      .mask_i  (best_mask[l]),
      .idx_o   (pick_idx[l]),
      .found_o (pick_found[l])
    );
  end

  always_comb begin
    for (int s = 0; s < SLOTS; s++) begin
      pos_sum[s]   = {1'b0, slots_q[s].pos} + (POS_W+1)'(speed);
      moved_pos[s] = pos_sum[s][POS_W] ? {POS_W{1'b1}} : pos_sum[s][POS_W-1:0];
    end
  end

  always_comb begin
    strum_free = '0;
    hit_d      = '0;
    bad_d      = '0;
    for (int l = 0; l < LANES; l++) begin
      if (strum[l]) begin
        if (pick_found[l]) begin
          hit_d[l] = 1'b1;
        end else begin
          bad_d[l] = 1'b1;
        end
      end
      for (int s = 0; s < SLOTS; s++) begin
        if (strum[l] && pick_found[l] && (pick_idx[l] == IDX_W'(s))) begin
          strum_free[s] = 1'b1;
        end
      end
    end
  end

  assign alloc_we = (state_q == ALLOC) && pend_found && free_found;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    ovf_d   = ovf_q;
    miss_d  = '0;
    cnt_d   = '0;
    for (int s = 0; s < SLOTS; s++) begin
      slots_d[s] = slots_q[s];
    end

    for (int s = 0; s < SLOTS; s++) begin
      if (strum_free[s]) begin
        slots_d[s] = '0;
      end else if (tick && slots_q[s].valid) begin
        if ({1'b0, moved_pos[s]} > WIN_HI) begin
          slots_d[s]                 = '0;
          miss_d[slots_q[s].lane] = 1'b1;
        end else begin
          slots_d[s].pos = moved_pos[s];
        end
      end
    end

    // The allocated slot was free at the start of the cycle, so nothing above touched it.
    for (int s = 0; s < SLOTS; s++) begin
      if (alloc_we && (free_idx == IDX_W'(s))) begin
        slots_d[s].valid = 1'b1;
        slots_d[s].lane  = pend_lane;
        slots_d[s].pos   = SPAWN_POS;
      end
    end

    case (state_q)
      IDLE: begin
        if (chart_valid && (chart_lanes != '0)) begin
          pend_d  = chart_lanes;
          state_d = ALLOC;
        end
      end
      ALLOC: begin
        if (pend_found) begin
          if (!free_found) begin
            ovf_d = 1'b1;
          end
          pend_d = pend_q & ~(LANES'(1) << pend_lane);
        end
        if (pend_d == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    for (int s = 0; s < SLOTS; s++) begin
      cnt_d = cnt_d + CNT_W'(slots_d[s].valid);
    end
  end

  always_comb begin
    rd_slot = '0;
    for (int s = 0; s < SLOTS; s++) begin
      if (rd_idx == IDX_W'(s)) begin
        rd_slot = slots_q[s];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
      bad_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      rd_q    <= '0;
      for (int s = 0; s < SLOTS; s++) begin
        slots_q[s] <= '0;
      end
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
      bad_q   <= bad_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      rd_q    <= rd_slot;
      for (int s = 0; s < SLOTS; s++) begin
        slots_q[s] <= slots_d[s];
      end
    end
  end

  assign chart_ready  = (state_q == IDLE);
  assign hit          = hit_q;
  assign miss         = miss_q;
  assign bad_strum    = bad_q;
  assign rd_valid     = rd_q.valid;
  assign rd_lane      = rd_q.lane;
  assign rd_pos       = rd_q.pos;
  assign active_count = cnt_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_note_lane_scroller.sv
// Bench for note_lane_scroller: directed table, hand-checked corner sequences and a random run against a slot-list model.
// A second small instance with a window past the screen edge exposes position saturation.
module tb_note_lane_scroller;

  localparam int SLOTS  = 40;
  localparam int WIN_LO = 404;
  localparam int WIN_HI = 436;
  localparam int MAXP   = 1023;

  logic       clock;
  logic       reset_n;
  logic       tick;
  logic [3:0] speed;
  logic       chart_valid;
  logic [3:0] chart_lanes;
  logic       chart_ready;
  logic [3:0] strum;
  logic [3:0] hit;
  logic [3:0] miss;
  logic [3:0] bad_strum;
  logic [5:0] rd_idx;
  logic       rd_valid;
  logic [1:0] rd_lane;
  logic [9:0] rd_pos;
  logic [5:0] active_count;
  logic       overflow;

  logic       tick_b;
  logic [3:0] speed_b;
  logic       chart_valid_b;
  logic [3:0] chart_lanes_b;
  logic       chart_ready_b;
  logic [3:0] strum_b;
  logic [3:0] hit_b;
  logic [3:0] miss_b;
  logic [3:0] bad_strum_b;
  logic [1:0] rd_idx_b;
  logic       rd_valid_b;
  logic [1:0] rd_lane_b;
  logic [9:0] rd_pos_b;
  logic [2:0] active_count_b;
  logic       overflow_b;

  note_lane_scroller dut (
    .clock(clock), .reset_n(reset_n), .tick(tick), .speed(speed),
    .chart_valid(chart_valid), .chart_lanes(chart_lanes), .chart_ready(chart_ready),
    .strum(strum), .hit(hit), .miss(miss), .bad_strum(bad_strum),
    .rd_idx(rd_idx), .rd_valid(rd_valid), .rd_lane(rd_lane), .rd_pos(rd_pos),
    .active_count(active_count), .overflow(overflow)
  );

  note_lane_scroller #(.SLOTS(4), .HIT_Y(1000), .HIT_WIN(30)) dut_sat (
    .clock(clock), .reset_n(reset_n), .tick(tick_b), .speed(speed_b),
    .chart_valid(chart_valid_b), .chart_lanes(chart_lanes_b), .chart_ready(chart_ready_b),
    .strum(strum_b), .hit(hit_b), .miss(miss_b), .bad_strum(bad_strum_b),
    .rd_idx(rd_idx_b), .rd_valid(rd_valid_b), .rd_lane(rd_lane_b), .rd_pos(rd_pos_b),
    .active_count(active_count_b), .overflow(overflow_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a plain list of slots plus a queue of lanes still waiting to be placed.
  bit m_valid [SLOTS];
  int m_lane  [SLOTS];
  int m_pos   [SLOTS];
  int pendq   [$];
  int e_hit, e_miss, e_bad, e_cnt, e_ovf, e_rdv, e_rdl, e_rdp;
  int ri_sel;

  typedef struct {
    bit cv; int cl; int ri;
    bit rdy; int cnt; bit rdv; int rdl; int rdp;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SLOTS; s++) begin
      m_valid[s] = 0; m_lane[s] = 0; m_pos[s] = 0;
    end
    pendq.delete();
    e_hit = 0; e_miss = 0; e_bad = 0; e_cnt = 0; e_ovf = 0;
    e_rdv = 0; e_rdl = 0; e_rdp = 0;
  endtask

  task automatic check_outputs();
    chk("chart_ready", chart_ready, (pendq.size() == 0) ? 1 : 0);
    chk("hit", hit, e_hit);
    chk("miss", miss, e_miss);
    chk("bad_strum", bad_strum, e_bad);
    chk("active_count", active_count, e_cnt);
    chk("overflow", overflow, e_ovf);
    chk("rd_valid", rd_valid, e_rdv);
    if (e_rdv != 0) begin
      chk("rd_lane", rd_lane, e_rdl);
      chk("rd_pos", rd_pos, e_rdp);
    end
  endtask

  task automatic model_step(input bit tk, input int sp, input bit cv, input int cl, input int st, input int ri);
    bit freed [SLOTS];
    int nh = 0;
    int nm = 0;
    int nb = 0;
    int a  = -1;
    int al = 0;
    int p;
    bit rdy;
    rdy   = (pendq.size() == 0);
    e_rdv = m_valid[ri]; e_rdl = m_lane[ri]; e_rdp = m_pos[ri];
    for (int s = 0; s < SLOTS; s++) freed[s] = 0;
    for (int ln = 0; ln < 4; ln++) begin
      int best = -1;
      for (int s = 0; s < SLOTS; s++) begin
        if (m_valid[s] && m_lane[s] == ln && m_pos[s] >= WIN_LO && m_pos[s] <= WIN_HI &&
            (best < 0 || m_pos[s] > m_pos[best])) best = s;
      end
      if (st[ln]) begin
        if (best >= 0) begin freed[best] = 1; nh |= (1 << ln); end
        else nb |= (1 << ln);
      end
    end
    if (!rdy) begin
      al = pendq.pop_front();
      for (int s = 0; s < SLOTS; s++) if (!m_valid[s]) begin a = s; break; end
      if (a < 0) e_ovf = 1;
    end
    if (tk) begin
      for (int s = 0; s < SLOTS; s++) begin
        if (m_valid[s] && !freed[s]) begin
          p = m_pos[s] + sp;
          if (p > MAXP) p = MAXP;
          if (p > WIN_HI) begin freed[s] = 1; nm |= (1 << m_lane[s]); end
          else m_pos[s] = p;
        end
      end
    end
    for (int s = 0; s < SLOTS; s++) begin
      if (freed[s]) begin m_valid[s] = 0; m_lane[s] = 0; m_pos[s] = 0; end
    end
    if (a >= 0) begin m_valid[a] = 1; m_lane[a] = al; m_pos[a] = 0; end
    if (rdy && cv && cl != 0) begin
      for (int ln = 0; ln < 4; ln++) if (cl[ln]) pendq.push_back(ln);
    end
    e_hit = nh; e_miss = nm; e_bad = nb;
    e_cnt = 0;
    for (int s = 0; s < SLOTS; s++) e_cnt += m_valid[s];
  endtask

  task automatic cyc(input bit tk, input int sp, input bit cv, input int cl, input int st);
    @(negedge clock);
    tick = tk; speed = 4'(sp); chart_valid = cv; chart_lanes = 4'(cl);
    strum = 4'(st); rd_idx = 6'(ri_sel);
    check_outputs();
    model_step(tk, sp, cv, cl, st, ri_sel);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic ticks(input int n, input int sp);
    for (int i = 0; i < n; i++) cyc(1, sp, 0, 0, 0);
  endtask

  task automatic peek();
    @(posedge clock);
    #1;
  endtask

  task automatic cyc1(input bit tk, input int sp, input bit cv, input int cl, input int st);
    @(negedge clock);
    tick_b = tk; speed_b = 4'(sp); chart_valid_b = cv; chart_lanes_b = 4'(cl); strum_b = 4'(st);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 2000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1, 5, 0, 1, 0, 0, 0, 0};
    tbl[1] = '{0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{0, 0, 0, 0, 1, 0, 0, 0};
    tbl[3] = '{0, 0, 0, 1, 2, 1, 0, 0};
    tbl[4] = '{0, 0, 1, 1, 2, 1, 0, 0};
    tbl[5] = '{0, 0, 1, 1, 2, 1, 2, 0};

    reset_n = 0; tick = 0; speed = 0; chart_valid = 0; chart_lanes = 0; strum = 0; rd_idx = 0;
    tick_b = 0; speed_b = 0; chart_valid_b = 0; chart_lanes_b = 0; strum_b = 0; rd_idx_b = 0;
    ri_sel = 0;
    model_reset();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset_n = 1;

    // Chord 0101: two allocation cycles, slots 0 and 1 filled in lane order.
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      tick = 0; speed = 4'd1; strum = 0;
      chart_valid = tbl[i].cv; chart_lanes = 4'(tbl[i].cl); rd_idx = 6'(tbl[i].ri);
      chk("tbl_ready", chart_ready, tbl[i].rdy);
      chk("tbl_count", active_count, tbl[i].cnt);
      chk("tbl_rd_valid", rd_valid, tbl[i].rdv);
      chk("tbl_rd_lane", rd_lane, tbl[i].rdl);
      chk("tbl_rd_pos", rd_pos, tbl[i].rdp);
      check_outputs();
      model_step(0, 1, tbl[i].cv, tbl[i].cl, 0, tbl[i].ri);
    end

    // Scroll to 400, then 404 stays inside the window; 437 falls out.
    ri_sel = 0;
    ticks(26, 15);
    cyc(1, 10, 0, 0, 0);
    cyc(1, 4, 0, 0, 0);
    peek();
    chk("no_miss_at_404", miss, 0);
    idle(1);
    peek();
    chk("pos_404", rd_pos, 404);
    ticks(2, 15);
    cyc(1, 2, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    peek();
    chk("miss_pulse", miss, 4'b0101);
    chk("count_after_miss", active_count, 0);
    idle(1);
    peek();
    chk("miss_once", miss, 0);

    // Two lane-1 notes at 430 and 410: first strum takes the deeper one.
    cyc(0, 0, 1, 4'b0010, 0);
    idle(2);
    cyc(1, 15, 0, 0, 0);
    cyc(1, 5, 0, 0, 0);
    cyc(0, 0, 1, 4'b0010, 0);
    idle(2);
    ticks(27, 15);
    cyc(1, 5, 0, 0, 0);
    ri_sel = 1;
    cyc(0, 0, 0, 0, 4'b0010);
    peek();
    chk("hit_first", hit, 4'b0010);
    chk("count_after_hit", active_count, 1);
    idle(1);
    peek();
    chk("hit_one_cycle", hit, 0);
    chk("survivor_valid", rd_valid, 1);
    chk("survivor_pos", rd_pos, 410);
    cyc(0, 0, 0, 0, 4'b0010);
    peek();
    chk("hit_second", hit, 4'b0010);
    chk("count_after_second", active_count, 0);

    cyc(0, 0, 0, 0, 4'b1000);
    peek();
    chk("bad_strum3", bad_strum, 4'b1000);
    chk("bad_no_hit", hit, 0);
    idle(1);
    peek();
    chk("bad_one_cycle", bad_strum, 0);

    // Tick and strum together at 420: the strum wins.
    ri_sel = 0;
    cyc(0, 0, 1, 4'b0001, 0);
    idle(2);
    ticks(28, 15);
    cyc(1, 15, 0, 0, 4'b0001);
    peek();
    chk("hit_with_tick", hit, 4'b0001);
    chk("no_miss_with_strum", miss, 0);
    chk("count_after_tick_hit", active_count, 0);

    // Fill every slot, drop one more, then reuse a strum-freed slot.
    for (int c = 0; c < 10; c++) begin
      cyc(0, 0, 1, 4'b1111, 0);
      idle(4);
    end
    ticks(28, 15);
    cyc(0, 0, 1, 4'b1000, 0);
    idle(1);
    peek();
    chk("overflow_set", overflow, 1);
    chk("count_full", active_count, 40);
    idle(3);
    peek();
    chk("overflow_sticky", overflow, 1);
    cyc(0, 0, 1, 4'b0001, 4'b0001);
    idle(2);
    peek();
    chk("realloc_valid", rd_valid, 1);
    chk("realloc_lane", rd_lane, 0);
    chk("realloc_pos", rd_pos, 0);
    chk("realloc_count", active_count, 40);

    // Reset in the middle of an allocation.
    cyc(0, 0, 1, 4'b1111, 0);
    idle(1);
    @(negedge clock);
    tick = 0; chart_valid = 0; chart_lanes = 0; strum = 0;
    reset_n = 0;
    #1;
    chk("rst_ready", chart_ready, 1);
    chk("rst_count", active_count, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_rd_valid", rd_valid, 0);
    model_reset();
    #2;
    reset_n = 1;

    for (int i = 0; i < 4000; i++) begin
      ri_sel = $urandom_range(0, SLOTS - 1);
      cyc($urandom_range(0, 1), $urandom_range(0, 15), ($urandom_range(0, 3) == 0),
          $urandom_range(0, 15),
          int'($urandom_range(0, 15) & $urandom_range(0, 15) & $urandom_range(0, 15)));
    end
    @(negedge clock);
    tick = 0; chart_valid = 0; strum = 0;

    // Window reaching past the screen edge: positions clamp at 1023 without a miss.
    cyc1(0, 0, 1, 4'b0001, 0);
    repeat (2) cyc1(0, 0, 0, 0, 0);
    repeat (68) cyc1(1, 15, 0, 0, 0);
    cyc1(1, 1, 0, 0, 0);
    cyc1(0, 0, 0, 0, 0);
    peek();
    chk("sat_pre_pos", rd_pos_b, 1021);
    cyc1(1, 15, 0, 0, 0);
    peek();
    chk("sat_no_miss", miss_b, 0);
    cyc1(0, 0, 0, 0, 0);
    peek();
    chk("sat_pos", rd_pos_b, 1023);
    chk("sat_count", active_count_b, 1);
    cyc1(0, 0, 0, 0, 4'b0001);
    peek();
    chk("sat_hit", hit_b, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
